// File: rtl/cg_axi5lite_regfile_if.sv
// AXI5-Lite bus bundle for the register file: the write request, write data,
// write response, read request and read data channels. Clock and reset are
// kept outside the bundle.
interface cg_axi5lite_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                AWPROT;

    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;

    logic                      BVALID;
    logic                      BREADY;

    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic [2:0]                ARPROT;

    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA
    );
endinterface

// File: rtl/cg_axi5lite_regfile.sv
// AXI5-Lite slave exposing NUM_REGS byte-writable registers. The write path
// holds one transaction at a time (AW and W may arrive in any order); the
// read path is independent and returns registered data one cycle after AR.
module cg_axi5lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    cg_axi5lite_regfile_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int HI_LSB = OFS + IDX_W;

    // Write-path state
    logic                  r_rst_done;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_bvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [NUM_REGS-1:0]   r_reg_wr;

    // Read-path state
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_wr_oor;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_oor;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_unused_ok;

    // Readies are held low until the first edge after reset release.
    assign s_axi.AWREADY = r_rst_done & ~r_aw_held & ~r_bvalid;
    assign s_axi.WREADY  = r_rst_done & ~r_w_held  & ~r_bvalid;
    assign s_axi.ARREADY = r_rst_done & ~r_rvalid;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.RVALID  = r_rvalid;
    assign s_axi.RDATA   = r_rdata;
    assign reg_wr_o      = r_reg_wr;

    assign w_aw_hs  = s_axi.AWVALID & s_axi.AWREADY;
    assign w_w_hs   = s_axi.WVALID  & s_axi.WREADY;
    assign w_ar_hs  = s_axi.ARVALID & s_axi.ARREADY;

    // Commit as soon as both halves are present, either held or arriving now.
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi.AWADDR;
    assign w_wr_data = r_w_held  ? r_wdata  : s_axi.WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi.WSTRB;

    assign w_wr_idx = w_wr_addr[OFS +: IDX_W];
    assign w_wr_oor = (w_wr_addr >> HI_LSB) != '0;
    assign w_rd_idx = s_axi.ARADDR[OFS +: IDX_W];
    assign w_rd_oor = (s_axi.ARADDR >> HI_LSB) != '0;

    // Protection attributes carry no meaning for this block.
    assign w_unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_reg;

            assign w_wr_sel[gi] = w_commit & ~w_wr_oor & (w_wr_idx == IDX_W'(gi));
            assign w_regs[gi]   = r_reg;
            assign reg_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_reg;

            // Byte-lane update of this register on a committed write.
            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    r_reg <= '0;
                end else if (w_wr_sel[gi]) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_wr_strb[k]) begin
                            r_reg[k*8 +: 8] <= w_wr_data[k*8 +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // Marks the first edge after reset release so readies come up there.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Write channel: capture AW/W, commit, then hold B until accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_reg_wr  <= '0;
        end else begin
            r_reg_wr <= w_wr_sel;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_axi.AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axi.WDATA;
                    r_wstrb  <= s_axi.WSTRB;
                end
                if (r_bvalid && s_axi.BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Read channel: register data on AR, hold it until R is accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_oor ? '0 : w_regs[w_rd_idx];
        end else if (r_rvalid && s_axi.RREADY) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cg_axi5lite_regfile.sv
// Directed bench for cg_axi5lite_regfile with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cg_axi5lite_regfile;
    logic         ACLK;
    logic         ARESETn;
    logic [255:0] reg_o;
    logic [7:0]   reg_wr_o;
    logic [255:0] exp_reg_o;
    int           checks;
    int           failures;

    cg_axi5lite_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

    cg_axi5lite_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi   (axi.slave),
        .reg_o   (reg_o),
        .reg_wr_o(reg_wr_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        axi.AWVALID = 0; axi.AWADDR = 0; axi.AWPROT = 0;
        axi.WVALID = 0;  axi.WDATA = 0;  axi.WSTRB = 0;
        axi.BREADY = 0;  axi.ARVALID = 0; axi.ARADDR = 0; axi.ARPROT = 0;
        axi.RREADY = 0;
        exp_reg_o = '0;
        tick(2);
        checks++; if ({axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b000) begin failures++; $display("FAIL reset_readies got=%b exp=000", {axi.AWREADY, axi.WREADY, axi.ARREADY}); end
        checks++; if ({axi.BVALID, axi.RVALID} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {axi.BVALID, axi.RVALID}); end
        checks++; if (reg_o !== exp_reg_o || reg_wr_o !== 8'h00 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL reset_regs reg_o=%h wr=%h rdata=%h exp=0", reg_o, reg_wr_o, axi.RDATA); end
        ARESETn = 1'b1;
        #1;
        checks++; if (axi.AWREADY !== 1'b0) begin failures++; $display("FAIL release_awready_early got=%b exp=0", axi.AWREADY); end
        tick();
        checks++; if ({axi.AWREADY, axi.WREADY, axi.ARREADY} !== 3'b111) begin failures++; $display("FAIL release_readies got=%b exp=111", {axi.AWREADY, axi.WREADY, axi.ARREADY}); end
    endtask

    task automatic test_write_same_cycle();
        axi.AWVALID = 1; axi.AWADDR = 32'h04; axi.AWPROT = 3'b111;
        axi.WVALID = 1;  axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'hF;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0;
        exp_reg_o[32 +: 32] = 32'hDEADBEEF;
        checks++; if (axi.BVALID !== 1'b1) begin failures++; $display("FAIL same_bvalid got=%b exp=1", axi.BVALID); end
        checks++; if (reg_o !== exp_reg_o) begin failures++; $display("FAIL same_reg got=%h exp=%h", reg_o, exp_reg_o); end
        checks++; if (reg_wr_o !== 8'h02) begin failures++; $display("FAIL same_wr_pulse got=%h exp=02", reg_wr_o); end
        tick();
        checks++; if (reg_wr_o !== 8'h00 || axi.BVALID !== 1'b1) begin failures++; $display("FAIL same_pulse_end wr=%h bvalid=%b exp=00/1", reg_wr_o, axi.BVALID); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
        checks++; if ({axi.BVALID, axi.AWREADY, axi.WREADY} !== 3'b011) begin failures++; $display("FAIL same_b_done got=%b exp=011", {axi.BVALID, axi.AWREADY, axi.WREADY}); end
    endtask

    task automatic test_w_before_aw();
        axi.WVALID = 1; axi.WDATA = 32'h11223344; axi.WSTRB = 4'h5;
        tick();
        axi.WVALID = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({axi.AWREADY, axi.WREADY, axi.BVALID} !== 3'b100) begin failures++; $display("FAIL wfirst_wait%0d got=%b exp=100", i, {axi.AWREADY, axi.WREADY, axi.BVALID}); end
            tick();
        end
        checks++; if (reg_o !== exp_reg_o) begin failures++; $display("FAIL wfirst_no_early got=%h exp=%h", reg_o, exp_reg_o); end
        axi.AWVALID = 1; axi.AWADDR = 32'h04;
        tick();
        axi.AWVALID = 0;
        exp_reg_o[32 +: 32] = 32'hDE22BE44;
        checks++; if (axi.BVALID !== 1'b1 || reg_wr_o !== 8'h02) begin failures++; $display("FAIL wfirst_commit bvalid=%b wr=%h exp=1/02", axi.BVALID, reg_wr_o); end
        checks++; if (reg_o !== exp_reg_o) begin failures++; $display("FAIL wfirst_reg got=%h exp=%h", reg_o, exp_reg_o); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
    endtask

    task automatic test_b_backpressure();
        axi.AWVALID = 1; axi.AWADDR = 32'h0C;
        axi.WVALID = 1;  axi.WDATA = 32'h00000033; axi.WSTRB = 4'hF;
        tick();
        axi.WVALID = 0;
        axi.AWADDR = 32'h10;
        exp_reg_o[96 +: 32] = 32'h33;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({axi.BVALID, axi.AWREADY, axi.WREADY} !== 3'b100) begin failures++; $display("FAIL bp_hold%0d got=%b exp=100", i, {axi.BVALID, axi.AWREADY, axi.WREADY}); end
            tick();
        end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
        checks++; if ({axi.BVALID, axi.AWREADY} !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", {axi.BVALID, axi.AWREADY}); end
        tick();
        axi.AWVALID = 0;
        checks++; if ({axi.AWREADY, axi.WREADY} !== 2'b01) begin failures++; $display("FAIL bp_aw2_taken got=%b exp=01", {axi.AWREADY, axi.WREADY}); end
        axi.WVALID = 1; axi.WDATA = 32'h00000044; axi.WSTRB = 4'hF;
        tick();
        axi.WVALID = 0;
        exp_reg_o[128 +: 32] = 32'h44;
        checks++; if (axi.BVALID !== 1'b1 || reg_wr_o !== 8'h10 || reg_o !== exp_reg_o) begin failures++; $display("FAIL bp_second bvalid=%b wr=%h reg=%h exp=1/10/%h", axi.BVALID, reg_wr_o, reg_o, exp_reg_o); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
    endtask

    task automatic test_read_backpressure();
        axi.ARVALID = 1; axi.ARADDR = 32'h04; axi.ARPROT = 3'b101;
        checks++; if (axi.ARREADY !== 1'b1) begin failures++; $display("FAIL rd_arready got=%b exp=1", axi.ARREADY); end
        tick();
        axi.ARVALID = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({axi.RVALID, axi.ARREADY} !== 2'b10 || axi.RDATA !== 32'hDE22BE44) begin failures++; $display("FAIL rd_hold%0d v/rdy=%b rdata=%h exp=10/de22be44", i, {axi.RVALID, axi.ARREADY}, axi.RDATA); end
            tick();
        end
        axi.RREADY = 1;
        tick();
        axi.RREADY = 0;
        checks++; if ({axi.RVALID, axi.ARREADY} !== 2'b01) begin failures++; $display("FAIL rd_done got=%b exp=01", {axi.RVALID, axi.ARREADY}); end
        axi.ARVALID = 1; axi.ARADDR = 32'h40;
        tick();
        axi.ARVALID = 0;
        checks++; if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL rd_oor rvalid=%b rdata=%h exp=1/0", axi.RVALID, axi.RDATA); end
        axi.RREADY = 1;
        tick();
        axi.RREADY = 0;
    endtask

    task automatic test_oor_and_zero_strb();
        axi.AWVALID = 1; axi.AWADDR = 32'h20;
        axi.WVALID = 1;  axi.WDATA = 32'hFFFFFFFF; axi.WSTRB = 4'hF;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0;
        checks++; if (axi.BVALID !== 1'b1 || reg_wr_o !== 8'h00 || reg_o !== exp_reg_o) begin failures++; $display("FAIL oor_write bvalid=%b wr=%h reg=%h exp=1/00/%h", axi.BVALID, reg_wr_o, reg_o, exp_reg_o); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
        axi.AWVALID = 1; axi.AWADDR = 32'h18;
        axi.WVALID = 1;  axi.WDATA = 32'h12345678; axi.WSTRB = 4'h0;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0;
        checks++; if (reg_wr_o !== 8'h40 || reg_o !== exp_reg_o) begin failures++; $display("FAIL zero_strb wr=%h reg=%h exp=40/%h", reg_wr_o, reg_o, exp_reg_o); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
        checks++; if (reg_wr_o !== 8'h00 || axi.BVALID !== 1'b0) begin failures++; $display("FAIL zero_strb_end wr=%h bvalid=%b exp=00/0", reg_wr_o, axi.BVALID); end
    endtask

    task automatic test_read_write_collision();
        axi.AWVALID = 1; axi.AWADDR = 32'h08;
        axi.WVALID = 1;  axi.WDATA = 32'hA5A5A5A5; axi.WSTRB = 4'hF;
        axi.ARVALID = 1; axi.ARADDR = 32'h08;
        tick();
        axi.AWVALID = 0; axi.WVALID = 0; axi.ARVALID = 0;
        exp_reg_o[64 +: 32] = 32'hA5A5A5A5;
        checks++; if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL coll_rdata rvalid=%b rdata=%h exp=1/0", axi.RVALID, axi.RDATA); end
        checks++; if (reg_o !== exp_reg_o) begin failures++; $display("FAIL coll_reg got=%h exp=%h", reg_o, exp_reg_o); end
        axi.RREADY = 1; axi.BREADY = 1;
        tick();
        axi.RREADY = 0; axi.BREADY = 0;
        axi.ARVALID = 1; axi.ARADDR = 32'h08;
        tick();
        axi.ARVALID = 0;
        checks++; if (axi.RDATA !== 32'hA5A5A5A5) begin failures++; $display("FAIL coll_reread got=%h exp=a5a5a5a5", axi.RDATA); end
        axi.RREADY = 1;
        tick();
        axi.RREADY = 0;
    endtask

    task automatic test_reset_mid();
        axi.AWVALID = 1; axi.AWADDR = 32'h1C;
        axi.ARVALID = 1; axi.ARADDR = 32'h04;
        tick();
        axi.AWVALID = 0; axi.ARVALID = 0;
        checks++; if ({axi.AWREADY, axi.RVALID} !== 2'b01) begin failures++; $display("FAIL mid_pre got=%b exp=01", {axi.AWREADY, axi.RVALID}); end
        #2 ARESETn = 1'b0;
        #1;
        exp_reg_o = '0;
        checks++; if ({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID} !== 5'b0 || axi.RDATA !== 32'h0) begin failures++; $display("FAIL mid_async flags=%b rdata=%h exp=0/0", {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID}, axi.RDATA); end
        checks++; if (reg_o !== exp_reg_o || reg_wr_o !== 8'h00) begin failures++; $display("FAIL mid_regs reg=%h wr=%h exp=0", reg_o, reg_wr_o); end
        #2 ARESETn = 1'b1;
        tick();
        axi.WVALID = 1; axi.WDATA = 32'h00000077; axi.WSTRB = 4'hF;
        tick();
        axi.WVALID = 0;
        tick();
        checks++; if (reg_o !== exp_reg_o || axi.BVALID !== 1'b0) begin failures++; $display("FAIL mid_discard reg=%h bvalid=%b exp=0/0", reg_o, axi.BVALID); end
        checks++; if ({axi.AWREADY, axi.WREADY} !== 2'b10) begin failures++; $display("FAIL mid_w_held got=%b exp=10", {axi.AWREADY, axi.WREADY}); end
        axi.AWVALID = 1; axi.AWADDR = 32'h00;
        tick();
        axi.AWVALID = 0;
        exp_reg_o[0 +: 32] = 32'h77;
        checks++; if (axi.BVALID !== 1'b1 || reg_o !== exp_reg_o || reg_wr_o !== 8'h01) begin failures++; $display("FAIL mid_after bvalid=%b reg=%h wr=%h exp=1/%h/01", axi.BVALID, reg_o, reg_wr_o, exp_reg_o); end
        axi.BREADY = 1;
        tick();
        axi.BREADY = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_b_backpressure();
        test_read_backpressure();
        test_oor_and_zero_strb();
        test_read_write_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cg_axi5lite_regfile.md
CG_AXI5LITE_REGFILE -- requirements
Module: cg_axi5lite_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning number of DATA_WIDTH registers (power of 2, at least 2).
REQ-004 SHALL have port ACLK, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARESETn, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have ports AWVALID in 1, AWREADY out 1, AWADDR in ADDR_WIDTH, AWPROT in 3, meaning AXI5-Lite write request channel (slave side).
REQ-007 SHALL have ports WVALID in 1, WREADY out 1, WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, meaning write data channel.
REQ-008 SHALL have ports BVALID out 1, BREADY in 1, meaning write response channel (no response code).
REQ-009 SHALL have ports ARVALID in 1, ARREADY out 1, ARADDR in ADDR_WIDTH, ARPROT in 3, meaning read request channel.
REQ-010 SHALL have ports RVALID out 1, RREADY in 1, RDATA out DATA_WIDTH, meaning read data channel.
REQ-011 SHALL have port reg_o, output, NUM_REGS*DATA_WIDTH, meaning current register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port reg_wr_o, output, NUM_REGS, meaning one-cycle pulse per register updated by a committed write.

Function
REQ-013 SHALL decode register index as ADDR[OFS +: log2(NUM_REGS)], OFS = log2(DATA_WIDTH/8); index bits above the register range nonzero -> out-of-range.
REQ-014 SHALL ignore AWPROT and ARPROT.
REQ-015 Write path SHALL hold at most one transaction; state = {aw_held, w_held, BVALID}.
REQ-016 AWREADY SHALL be 1 iff aw_held=0 and BVALID=0; WREADY SHALL be 1 iff w_held=0 and BVALID=0.
REQ-017 AW and W SHALL be accepted in any order or in the same cycle; accepted address/data/strobe captured into holding registers.
REQ-018 Write SHALL commit on the edge where address and data are both available (held or handshaking that cycle): bytes with WSTRB[k]=1 updated, others unchanged; aw_held/w_held cleared; BVALID set.
REQ-019 Out-of-range write SHALL complete the handshake and assert BVALID with no register change and no reg_wr_o pulse.
REQ-020 reg_wr_o[i] SHALL pulse for exactly the cycle after commit if index i is in range, even when WSTRB=0.
REQ-021 BVALID SHALL stay 1 until sampled with BREADY=1, then clear; next AW/W acceptable the following cycle (no bypass).
REQ-022 Minimum write latency: AW+W handshake in cycle N -> BVALID=1 in cycle N+1.
REQ-023 ARREADY SHALL be 1 iff RVALID=0.
REQ-024 On AR handshake in cycle N, RDATA SHALL be registered and RVALID=1 in cycle N+1; RDATA = register contents, or 0 if out-of-range.
REQ-025 RVALID and RDATA SHALL stay stable until sampled with RREADY=1, then RVALID clears.
REQ-026 Read and write paths SHALL be independent; AR handshake in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-027 reg_o SHALL reflect a committed write from the cycle after commit.

Reset
REQ-028 ARESETn=0 SHALL asynchronously clear all registers to 0, reg_wr_o to 0, BVALID=0, RVALID=0, RDATA=0, aw_held=0, w_held=0.
REQ-029 During reset AWREADY, WREADY and ARREADY SHALL be 0; they assume REQ-016/REQ-023 values on the first edge after deassertion.
REQ-030 Reset mid-transaction SHALL discard held AW/W and pending B/R with no register update.

Verification
REQ-031 AW(0x04)+W(0xDEADBEEF, strb 0xF) same cycle -> BVALID next cycle, reg1=0xDEADBEEF, reg_wr_o=0x02 one cycle.
REQ-032 W(0x11223344, strb 0x5) three cycles before AW(0x04), reg1 previously 0xDEADBEEF -> reg1=0xDE22BE44; AWREADY stays 1 and WREADY 0 while waiting.
REQ-033 BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0; a second AW is accepted only after the B handshake.
REQ-034 AR(0x04) with RREADY=0 for 4 cycles -> RVALID=1, RDATA stable, ARREADY=0; AR(0x40) with NUM_REGS=8 -> RDATA=0.
REQ-035 AR(0x08) and write-commit to 0x08 (data 0xA5A5A5A5, old 0) in the same cycle -> RDATA=0, reg2=0xA5A5A5A5 next cycle.
REQ-036 ARESETn pulsed low with AW held and RVALID=1 -> all outputs 0 immediately, no register change after release.
